// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Widths here describe the default 32x32 register file.
package regfile_wb_pkg;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int NUM_REGS  = 2 ** RF_ADDR_W;
    localparam int REG_ZERO  = 0;

    typedef logic [RF_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic                 valid;
        reg_addr_t            addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: first set request at or after ptr (wrapping) wins.
// Outputs a one-hot grant plus its binary index; no grant when en=0.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ write-back producers and
// keeps a per-register pending scoreboard for operand hazard detection.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_w_addr,
    output logic [DATA_W-1:0]         rf_write_data,
    input  logic                      claim_valid,
    input  logic [ADDR_W-1:0]         claim_addr,
    output logic                      claim_ready,
    input  logic [ADDR_W-1:0]         chk_addr_1,
    input  logic [ADDR_W-1:0]         chk_addr_2,
    output logic                      hazard_1,
    output logic                      hazard_2,
    output logic [2**ADDR_W-1:0]      pending
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [ADDR_W-1:0]     addr_arr [NUM_REQ];
    logic [DATA_W-1:0]     data_arr [NUM_REQ];
    logic [PTR_W-1:0]      rr_ptr_reg, rr_ptr_next, gnt_idx;
    logic                  xfer;
    logic                  rf_we_reg;
    logic [ADDR_W-1:0]     rf_w_addr_reg;
    logic [DATA_W-1:0]     rf_write_data_reg;
    logic [2**ADDR_W-1:0]  pending_reg, pending_next;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N(NUM_REQ), .IW(PTR_W)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_reg),
        .en      (!hold),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    // A grant is only ever raised on a valid request, so any grant is a transfer.
    assign xfer        = |req_ready;
    assign rr_ptr_next = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);

    assign claim_ready = claim_valid & ((claim_addr == ZERO_ADDR) | !pending_reg[claim_addr]);
    assign hazard_1    = (chk_addr_1 != ZERO_ADDR) & pending_reg[chk_addr_1];
    assign hazard_2    = (chk_addr_2 != ZERO_ADDR) & pending_reg[chk_addr_2];

    // Clear first, then set, so a claim landing on the committing register wins.
    always_comb begin
        pending_next = pending_reg;
        if (rf_we_reg)
            pending_next[rf_w_addr_reg] = 1'b0;
        if (claim_ready && claim_addr != ZERO_ADDR)
            pending_next[claim_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_reg         <= 1'b0;
            rf_w_addr_reg     <= '0;
            rf_write_data_reg <= '0;
            rr_ptr_reg        <= '0;
            pending_reg       <= '0;
        end else begin
            pending_reg <= pending_next;
            if (xfer) begin
                rf_we_reg         <= (addr_arr[gnt_idx] != ZERO_ADDR);
                rf_w_addr_reg     <= addr_arr[gnt_idx];
                rf_write_data_reg <= data_arr[gnt_idx];
                rr_ptr_reg        <= rr_ptr_next;
            end else begin
                rf_we_reg <= 1'b0;
            end
        end
    end

    assign rf_we         = rf_we_reg;
    assign rf_w_addr     = rf_w_addr_reg;
    assign rf_write_data = rf_write_data_reg;
    assign pending       = pending_reg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a behavioural model checked every
// cycle plus hand-computed expectations for each scenario.
module tb_regfile_wb_arbiter;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            hold = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            rf_we;
    logic [AW-1:0]   rf_w_addr;
    logic [DW-1:0]   rf_write_data;
    logic            claim_valid = 1'b0;
    logic [AW-1:0]   claim_addr = '0;
    logic            claim_ready;
    logic [AW-1:0]   chk_addr_1 = '0;
    logic [AW-1:0]   chk_addr_2 = '0;
    logic            hazard_1, hazard_2;
    logic [31:0]     pending;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_write_data(rf_write_data),
        .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(claim_ready),
        .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
        .hazard_1(hazard_1), .hazard_2(hazard_2), .pending(pending)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int        m_ptr = 0;
    bit        m_we = 0;
    int        m_addr = 0;
    bit [31:0] m_data = 0;
    bit [31:0] m_pend = 0;

    function automatic int winner();
        if (hold) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic bit m_claim_ok();
        return claim_valid && (claim_addr == 0 || !m_pend[claim_addr]);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_pend = 0;
        end else begin
            int        w;
            bit [31:0] np;
            w  = winner();
            np = m_pend;
            if (m_we) np[m_addr] = 1'b0;
            if (m_claim_ok() && claim_addr != 0) np[claim_addr] = 1'b1;
            m_pend = np;
            if (w >= 0) begin
                m_addr = int'(req_addr[w*AW +: AW]);
                m_data = req_data[w*DW +: DW];
                m_we   = (m_addr != 0);
                m_ptr  = (w + 1) % N;
            end else begin
                m_we = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int        w;
        bit [N-1:0] er;
        w  = winner();
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("model_req_ready", 32'(req_ready), 32'(er));
        chk("model_rf_we", 32'(rf_we), 32'(m_we));
        chk("model_rf_w_addr", 32'(rf_w_addr), 32'(m_addr));
        chk("model_rf_write_data", rf_write_data, m_data);
        chk("model_pending", pending, m_pend);
        chk("model_claim_ready", 32'(claim_ready), 32'(m_claim_ok()));
        chk("model_hazard_1", 32'(hazard_1), 32'(chk_addr_1 != 0 && m_pend[chk_addr_1]));
        chk("model_hazard_2", 32'(hazard_2), 32'(chk_addr_2 != 0 && m_pend[chk_addr_2]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input logic [31:0] d);
        req_addr[i*AW +: AW] = AW'(a);
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        repeat (2) step();
        reset = 1'b0;
        #1;
        chk("reset_rf_we", 32'(rf_we), 0);
        chk("reset_pending", pending, 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rf_w_addr", 32'(rf_w_addr), 0);
        step();

        // All three requesters valid: strict rotation 0,1,2,0,1,2
        for (int i = 0; i < N; i++) set_req(i, i + 1, 32'h100 + 32'(i));
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr_grant_%0d", c), 32'(req_ready), 32'(1 << (c % 3)));
            if (c > 0) begin
                chk($sformatf("rr_we_%0d", c), 32'(rf_we), 1);
                chk($sformatf("rr_addr_%0d", c), 32'(rf_w_addr), 32'(((c - 1) % 3) + 1));
            end
            step();
        end
        req_valid = '0;
        #1;
        chk("rr_last_addr", 32'(rf_w_addr), 3);
        chk("rr_last_data", rf_write_data, 32'h102);

        // Write to r0 is granted but never reaches the register file
        set_req(2, 0, 32'hDEADBEEF);
        req_valid = 3'b100;
        #1 chk("r0_ready", 32'(req_ready), 32'b100);
        step();
        req_valid = 3'b011;
        #1;
        chk("r0_no_we", 32'(rf_we), 0);
        chk("r0_ptr_wrapped", 32'(req_ready), 32'b001);
        step();
        req_valid = '0;

        // Claim r5, see hazard, reject re-claim, commit via requester 1
        claim_valid = 1'b1; claim_addr = 5;
        #1 chk("claim5_ready", 32'(claim_ready), 1);
        step();
        chk_addr_1 = 5;
        #1;
        chk("claim5_pending", 32'(pending[5]), 1);
        chk("claim5_hazard", 32'(hazard_1), 1);
        chk("claim5_reclaim", 32'(claim_ready), 0);
        step();
        claim_valid = 1'b0;
        set_req(1, 5, 32'h55);
        req_valid = 3'b010;
        #1 chk("wr5_ready", 32'(req_ready), 32'b010);
        step();
        req_valid = '0;
        #1;
        chk("wr5_we", 32'(rf_we), 1);
        chk("wr5_addr", 32'(rf_w_addr), 5);
        chk("wr5_still_hazard", 32'(hazard_1), 1);
        step();
        #1;
        chk("wr5_cleared", 32'(pending[5]), 0);
        chk("wr5_no_hazard", 32'(hazard_1), 0);

        // Commit to r7 while claiming r7 in the same cycle: set wins
        set_req(0, 7, 32'h77);
        req_valid = 3'b001;
        #1 chk("wr7_ready", 32'(req_ready), 32'b001);
        step();
        req_valid = '0;
        claim_valid = 1'b1; claim_addr = 7; chk_addr_2 = 7;
        #1;
        chk("wr7_we", 32'(rf_we), 1);
        chk("wr7_addr", 32'(rf_w_addr), 7);
        chk("claim7_ready", 32'(claim_ready), 1);
        step();
        claim_valid = 1'b0;
        #1;
        chk("claim7_pending", 32'(pending[7]), 1);
        chk("claim7_hazard", 32'(hazard_2), 1);

        // hold blocks grants; release grants requester 1, pointer moves to 2
        hold = 1'b1;
        set_req(1, 9, 32'h99);
        req_valid = 3'b010;
        #1 chk("hold_ready", 32'(req_ready), 0);
        step();
        #1 chk("hold_no_we", 32'(rf_we), 0);
        hold = 1'b0;
        #1 chk("unhold_ready", 32'(req_ready), 32'b010);
        step();
        set_req(2, 3, 32'h33);
        req_valid = 3'b111;
        #1 chk("ptr_at_2", 32'(req_ready), 32'b100);
        step();
        req_valid = '0;

        // Asynchronous reset in the middle of a committed write
        claim_valid = 1'b1; claim_addr = 9;
        step();
        claim_valid = 1'b0;
        set_req(0, 9, 32'h909);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        #1;
        chk("pre_rst_we", 32'(rf_we), 1);
        chk("pre_rst_pending", 32'(pending[9]), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_we", 32'(rf_we), 0);
        chk("async_rst_pending", pending, 0);
        step();
        reset = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x32 register file among NUM_REQ write-back producers: ALU result, load data, and the mult/div unit.
- Round-robin grant with valid/ready handshake.
- Registered drive of the register file's we, w_addr and write_data.
- Per-register pending scoreboard, so the control FSM can stall operand reads until the producer commits.
- Sits between the execution units and the register file; queried by the multicycle controller.

Parameters:
NUM_REQ, 3, number of write-back requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
hold  in  1  controller freeze; when 1, no grants are issued
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
req_addr  in  NUM_REQ*ADDR_W  packed destination register addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data, same packing
rf_we  out  1  register file write enable
rf_w_addr  out  ADDR_W  register file write address
rf_write_data  out  DATA_W  register file write data
claim_valid  in  1  issuing instruction reserves a destination register
claim_addr  in  ADDR_W  register being reserved
claim_ready  out  1  reservation accepted this cycle
chk_addr_1  in  ADDR_W  source operand 1 address
chk_addr_2  in  ADDR_W  source operand 2 address
hazard_1  out  1  operand 1 still has an outstanding write
hazard_2  out  1  operand 2 still has an outstanding write
pending  out  2**ADDR_W  scoreboard bit vector (debug/observation)

Behaviour:
- Reset (asynchronous, immediate): rf_we=0, rf_w_addr=0, rf_write_data=0, pending=0, rr_ptr=0. Combinational outputs then follow from this state.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ. The first set bit is the winner.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - If hold=1 or no req_valid is set, req_ready=0.
  - A transfer occurs when req_valid[i] & req_ready[i].
- Pointer: on a transfer from index i, rr_ptr <= (i+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0). It is unchanged otherwise.
- Output stage (1-cycle latency, registered):
  - After a transfer edge: rf_we=1, rf_w_addr=req_addr[i], rf_write_data=req_data[i].
  - In a cycle with no transfer: rf_we <= 0; addr/data hold their last values.
  - A transfer with addr 0 is accepted (ready asserted) but rf_we <= 0, so r0 is never written.
- Throughput: one transfer per cycle; back-to-back grants are allowed. Requesters must hold valid, addr and data stable until ready.
- Scoreboard:
  - claim_ready = claim_valid & (claim_addr==0 | !pending[claim_addr]).
  - Set: on a claim with claim_ready=1 and claim_addr!=0, pending[claim_addr] <= 1.
  - Clear: at the edge where rf_we=1, pending[rf_w_addr] <= 0. This coincides with the register file's own write edge, so no bypass is needed.
  - Simultaneous set and clear of the same address: set wins. This covers a new claim issued in the same cycle the old write commits, which is only possible because claim_ready uses the current pending value. Accordingly, claim_ready while pending[A]=1 and rf_we=1 for A is still 0. No look-ahead.
  - Claims with claim_addr==0 are accepted and have no effect.
  - A write to a non-pending register is legal; clearing an already-0 bit is a no-op.
- Hazard: hazard_k = (chk_addr_k!=0) & pending[chk_addr_k]. Combinational from state, no input-to-output path through the arbiter.
- hold does not affect the scoreboard or the output stage already loaded.

Decomposition:
- Package regfile_wb_pkg holds:
  - localparams NUM_REGS = 2**ADDR_W and REG_ZERO = 0;
  - a typedef for reg_addr_t (logic [ADDR_W-1:0]);
  - a typedef for wb_req_t (struct: valid, addr, data).
- One sub-module, rr_arbiter (parameter N; inputs req, ptr, en; output one-hot gnt and binary gnt_idx), instantiated once.
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset release, idle → rf_we=0, pending=0, all req_ready=0; assert reset mid-transfer → rf_we drops to 0 asynchronously and pending clears.
- req_valid=3'b111 held 6 cycles with addrs 1/2/3 → grants in order 0,1,2,0,1,2; rf_we=1 from cycle 1 on, rf_w_addr sequence 1,2,3,1,2,3 one cycle after each grant.
- Requester 2 writes addr 0, data 0xDEADBEEF → req_ready[2]=1, rf_we stays 0 next cycle, rr_ptr advances to 0.
- claim addr 5 → pending[5]=1, chk_addr_1=5 gives hazard_1=1; second claim to 5 → claim_ready=0; requester 1 writes 5 → rf_we=1, addr 5; after that edge pending[5]=0 and hazard_1=0.
- rf_we=1 for addr 7 with pending[7]=0 while claim addr 7 in the same cycle → claim_ready=1, pending[7]=1 after the edge (set wins).
- hold=1 with req_valid=3'b010 → req_ready=0 and rf_we=0 after the edge; hold=0 → grant to requester 1 and rr_ptr=2.
